// File: rtl/psram_arb_pkg.sv
// Shared definitions for the two-port PSRAM memory arbiter.
//   arb_state_t : arbitration FSM state encoding (S_IDLE, S_OWN0, S_OWN1, S_DRAIN)
//   NUM_PORTS   : number of requester ports
//   clog2       : ceiling log2, used to size the watchdog counter
package psram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN0  = 2'd1,
        S_OWN1  = 2'd2,
        S_DRAIN = 2'd3
    } arb_state_t;

    localparam int NUM_PORTS = 2;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/psram_port_mux.sv
// Combinational steering between two requester ports and the PSRAM core.
//   grant       : one-hot owner (00 = no owner, forces all mem_* low)
//   mN_*        : requester bundles (cs/we/addr/sel/burst/din in, dout/busy/ack out)
//   mem_*       : core-side request bundle and core responses
module psram_port_mux
    import psram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 24
) (
    input  logic [NUM_PORTS-1:0] grant,

    input  logic                 m0_cs,
    input  logic                 m0_we,
    input  logic [ADDR_BITS-1:2] m0_addr,
    input  logic [3:0]           m0_sel,
    input  logic                 m0_burst,
    input  logic [31:0]          m0_din,
    output logic [31:0]          m0_dout,
    output logic                 m0_busy,
    output logic                 m0_ack,

    input  logic                 m1_cs,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:2] m1_addr,
    input  logic [3:0]           m1_sel,
    input  logic                 m1_burst,
    input  logic [31:0]          m1_din,
    output logic [31:0]          m1_dout,
    output logic                 m1_busy,
    output logic                 m1_ack,

    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:2] mem_addr,
    output logic [3:0]           mem_sel,
    output logic                 mem_burst,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_busy,
    input  logic                 mem_ack
);

    always_comb begin
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_sel   = 4'b0000;
        mem_burst = 1'b0;
        mem_din   = 32'h0;
        unique case (grant)
            2'b01: begin
                mem_cs    = m0_cs;
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_sel   = m0_sel;
                mem_burst = m0_burst;
                mem_din   = m0_din;
            end
            2'b10: begin
                mem_cs    = m1_cs;
                mem_we    = m1_we;
                mem_addr  = m1_addr;
                mem_sel   = m1_sel;
                mem_burst = m1_burst;
                mem_din   = m1_din;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; requesters qualify it with their own ack.
    assign m0_dout = mem_dout;
    assign m1_dout = mem_dout;
    assign m0_ack  = mem_ack & grant[0];
    assign m1_ack  = mem_ack & grant[1];
    assign m0_busy = ~grant[0] | mem_busy;
    assign m1_busy = ~grant[1] | mem_busy;

endmodule

// File: rtl/psram_mem_arbiter.sv
// Two-port round-robin arbiter in front of one PSRAM core memory interface.
//   clk, rst    : core clock, synchronous active-high reset
//   mN_*        : requester ports 0 and 1 (cs/we/addr/sel/burst/din in;
//                 dout/busy/ack/err out, err is a one-cycle watchdog abort pulse)
//   mem_*       : core-side request bundle and core responses
//   grant       : one-hot current owner (debug)
// A grant is held until the owner's transaction ends; DRAIN then waits for the
// core to go idle before any new grant. A no-ack watchdog aborts hung owners.
module psram_mem_arbiter
    import psram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_cs,
    input  logic                 m0_we,
    input  logic [ADDR_BITS-1:2] m0_addr,
    input  logic [3:0]           m0_sel,
    input  logic                 m0_burst,
    input  logic [31:0]          m0_din,
    output logic [31:0]          m0_dout,
    output logic                 m0_busy,
    output logic                 m0_ack,
    output logic                 m0_err,

    input  logic                 m1_cs,
    input  logic                 m1_we,
    input  logic [ADDR_BITS-1:2] m1_addr,
    input  logic [3:0]           m1_sel,
    input  logic                 m1_burst,
    input  logic [31:0]          m1_din,
    output logic [31:0]          m1_dout,
    output logic                 m1_busy,
    output logic                 m1_ack,
    output logic                 m1_err,

    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:2] mem_addr,
    output logic [3:0]           mem_sel,
    output logic                 mem_burst,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_busy,
    input  logic                 mem_ack,

    output logic [1:0]           grant
);

    // A zero-width counter is not legal, so a disabled watchdog keeps one bit.
    localparam int WD_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            rr_last_q, rr_last_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [1:0]      err_q, err_d;

    logic            own_cs;
    logic            own_burst;
    logic            wd_expire;
    logic [1:0]      mux_grant;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_last_d = rr_last_q;
        wd_cnt_d  = wd_cnt_q;
        err_d     = 2'b00;
        own_cs    = (state_q == S_OWN1) ? m1_cs    : m0_cs;
        own_burst = (state_q == S_OWN1) ? m1_burst : m0_burst;
        wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST) && !mem_ack;

        case (state_q)
            S_IDLE: begin
                // rr_last==1 means port 1 owned last, so port 0 wins a tie.
                if (m0_cs && (!m1_cs || rr_last_q)) begin
                    state_d  = S_OWN0;
                    grant_d  = 2'b01;
                    wd_cnt_d = '0;
                end else if (m1_cs) begin
                    state_d  = S_OWN1;
                    grant_d  = 2'b10;
                    wd_cnt_d = '0;
                end
            end
            S_OWN0, S_OWN1: begin
                if (mem_ack) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
                if (!own_cs || (mem_ack && !own_burst) || wd_expire) begin
                    state_d   = S_DRAIN;
                    grant_d   = 2'b00;
                    rr_last_d = (state_q == S_OWN1);
                    err_d     = wd_expire ? grant_q : 2'b00;
                end
            end
            S_DRAIN: begin
                if (!mem_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 2'b00;
            rr_last_q <= 1'b1;
            wd_cnt_q  <= '0;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            wd_cnt_q  <= wd_cnt_d;
            err_q     <= err_d;
        end
    end

    // Reset masks the owner immediately so the core sees cs low and nobody gets an ack.
    assign mux_grant = rst ? 2'b00 : grant_q;
    assign grant     = grant_q;
    assign m0_err    = err_q[0];
    assign m1_err    = err_q[1];

    psram_port_mux #(
        .ADDR_BITS (ADDR_BITS)
    ) u_port_mux (
        .grant     (mux_grant),
        .m0_cs     (m0_cs),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_sel    (m0_sel),
        .m0_burst  (m0_burst),
        .m0_din    (m0_din),
        .m0_dout   (m0_dout),
        .m0_busy   (m0_busy),
        .m0_ack    (m0_ack),
        .m1_cs     (m1_cs),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_sel    (m1_sel),
        .m1_burst  (m1_burst),
        .m1_din    (m1_din),
        .m1_dout   (m1_dout),
        .m1_busy   (m1_busy),
        .m1_ack    (m1_ack),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_sel   (mem_sel),
        .mem_burst (mem_burst),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .mem_busy  (mem_busy),
        .mem_ack   (mem_ack)
    );

endmodule
